uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
Byte-serialising UART transmitter. It consumes the divided bit-rate clock produced by clkdiv and drives a top-level serial output such as io_tx. A valid/ready handshake accepts one word per frame, and each frame is shifted out LSB-first with start, optional parity and stop bits. All logic runs in the single system clock domain; the divided clock is used only as a timing reference, never as a clock.

Parameters:
DataBits, 8, data word width (5..9)
Parity, 0, 0 = none, 1 = odd, 2 = even
StopBits, 1, number of stop bits (1 or 2)

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high reset
ckin  input  1  bit-rate reference from clkdiv ckout (level or pulse, synchronous to clock)
data  input  DataBits  word to send
valid  input  1  data is valid
ready  output  1  block can accept a word
tx  output  1  serial line, idle high
busy  output  1  a frame is in progress

Behaviour:
- Reset (async, active-high): tx=1, ready=1, busy=0, state=IDLE, shift register=0, bit counter=0, ckin history register=0.
- Tick generation: ckin is registered once; tick = ckin & ~ckin_q (rising edge). This gives exactly one tick per ckin period, whether ckin is a square wave or a 1-cycle pulse.
- Handshake:
  - A transfer occurs on a clock edge where valid & ready.
  - On that edge: data is latched, parity bit is computed from the latched data, ready goes 0 and busy goes 1 on the next cycle.
  - ready=1 only in IDLE. valid while busy is ignored. data changes after acceptance have no effect.
- FSM states: IDLE, SYNC, START, DATA, PAR, STOP.
  - IDLE: tx=1. A transfer moves to SYNC.
  - SYNC: tx=1. Waits for the next tick, then goes to START and drives tx=0 in the cycle after that tick. This aligns the start bit to the bit grid.
  - START -> DATA on a tick. tx = shift[0]; the register shifts right on each tick.
  - DATA: after DataBits bit periods, go to PAR if Parity!=0, otherwise to STOP.
  - PAR: tx = parity bit for one bit period.
    - Even parity: bit = XOR of data bits.
    - Odd parity: bit = ~XOR of data bits.
  - STOP: tx=1 for StopBits bit periods, then IDLE. ready=1 in the cycle after the final tick.
- Each bit lasts exactly one tick interval. tx changes only in the cycle after a tick.
- Frame length: 1 + DataBits + (Parity!=0) + StopBits tick intervals, measured from the start bit edge.
- Back-to-back: valid held high when ready returns starts the next frame. Minimum idle between frames is the SYNC wait (up to one bit period, plus 1 clock).
- Bit counter width: $clog2(DataBits+1). It wraps back to 0 on each state change.
- Reset asserted mid-frame: tx returns to 1 immediately (asynchronously). The frame is discarded and not resumed after reset releases.
- A tick arriving in the same cycle as acceptance is not consumed. SYNC waits for the next tick.
- ckin held constant produces no ticks: the FSM stalls in its current state with tx holding its current value.

Decomposition:
- Package uart_pkg holds:
  - parity_t enum (NONE, ODD, EVEN)
  - state_t enum (IDLE, SYNC, START, DATA, PAR, STOP)
  - localparam functions for frame length.
- One sub-module, edge_tick: registers ckin and emits a single-cycle tick on each rising edge. It has clock/reset ports and reset value 0. It is reusable by a future uart_rx.
- The FSM, shift register and parity logic stay in uart_tx.

Test Plan:
- Basic frame: defaults; ckin is a square wave with period 8 clocks; send 0x55 -> after the SYNC wait, tx reads 0,1,0,1,0,1,0,1,0,1, each bit 8 clocks; ready returns to 1 one cycle after the stop-bit tick.
- Even parity: Parity=2, send 0x07 -> data bits 1,1,1,0,0,0,0,0, parity bit 1, stop 1. Odd parity: Parity=1, send 0x07 -> parity bit 0.
- Two stop bits with back-to-back frames: StopBits=2, valid held high with 0xA3 then 0x3C -> each frame's stop bits last 16 clocks; second start bit aligned to a tick; no word lost or duplicated.
- Handshake rules: pulse valid with 0xFF while busy -> ignored; change data to 0x00 one cycle after acceptance -> line still sends 0x81 (the accepted value).
- Reset mid-frame: assert reset during data bit 3 -> tx=1 in the same cycle; after release, ready=1 and busy=0; next 0x0F frame is correct.
- Pulse-type ckin: ckin is a 1-cycle pulse every 5 clocks -> each bit lasts 5 clocks; a 5-clock stall with ckin held high produces no extra ticks.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and frame-length helpers for the UART blocks.
//   parity_t : parity selection (NONE, ODD, EVEN)
//   state_t  : transmitter FSM state encoding
//   frame_ticks / cnt_width : frame length and bit-counter sizing helpers
package uart_pkg;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    ODD  = 2'd1,
    EVEN = 2'd2
  } parity_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SYNC  = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
    PAR   = 3'd4,
    STOP  = 3'd5
  } state_t;

  // Bit periods in one frame, counted from the leading edge of the start bit.
  function automatic int unsigned frame_ticks(input int unsigned data_bits,
                                              input parity_t     parity,
                                              input int unsigned stop_bits);
    return 1 + data_bits + ((parity != NONE) ? 1 : 0) + stop_bits;
  endfunction

  // Width of a counter that can hold 0..data_bits.
  function automatic int unsigned cnt_width(input int unsigned data_bits);
    return $clog2(data_bits + 1);
  endfunction

endpackage

// File: rtl/edge_tick.sv
// Rising-edge detector for a bit-rate reference that is synchronous to clock.
// Produces exactly one tick per reference period, whether the reference is a
// square wave or a single-cycle pulse.
//   clock  : system clock
//   reset  : asynchronous active-high reset (history register clears to 0)
//   ckin   : bit-rate reference level
//   tick_c : combinational single-cycle tick on each rising edge of ckin
module edge_tick (
  input  logic clock,
  input  logic reset,
  input  logic ckin,
  output logic tick_c
);

  logic ckin_q;

  // One-cycle history of the reference.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ckin_q <= 1'b0;
    end else begin
      ckin_q <= ckin;
    end
  end

  assign tick_c = ckin & ~ckin_q;

endmodule

// File: rtl/uart_tx.sv
// Byte-serialising UART transmitter. Accepts one word per frame over a
// valid/ready handshake and shifts it out LSB-first with a start bit,
// optional parity bit and one or two stop bits. The divided bit-rate clock
// is only sampled as a timing reference; every register runs on clock.
//   clock : system clock
//   reset : asynchronous active-high reset
//   ckin  : bit-rate reference from the clock divider
//   data  : word to send, latched on acceptance
//   valid : data is valid
//   ready : transmitter can accept a word (IDLE only)
//   tx    : serial line, idle high
//   busy  : a frame is in progress
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DataBits = 8,
  parameter parity_t     Parity   = NONE,
  parameter int unsigned StopBits = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ckin,
  input  logic [DataBits-1:0] data,
  input  logic                valid,
  output logic                ready,
  output logic                tx,
  output logic                busy
);

  localparam int unsigned     CntW      = cnt_width(DataBits);
  localparam logic [CntW-1:0] LastData  = CntW'(DataBits - 1);
  localparam logic [CntW-1:0] LastStop  = CntW'(StopBits - 1);
  localparam logic [CntW-1:0] CntOne    = CntW'(1);
  localparam bit              HasParity = (Parity != NONE);

  logic                tick_c;
  state_t              state, state_d;
  logic [DataBits-1:0] shift_q, shift_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                par_q, par_d;
  logic                tx_d, ready_d, busy_d;

  edge_tick u_edge_tick (
    .clock  (clock),
    .reset  (reset),
    .ckin   (ckin),
    .tick_c (tick_c)
  );

  // State and datapath registers; tx drops to idle high as soon as reset rises.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
      tx      <= 1'b1;
      ready   <= 1'b1;
      busy    <= 1'b0;
    end else begin
      state   <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      tx      <= tx_d;
      ready   <= ready_d;
      busy    <= busy_d;
    end
  end

  // Next-state and next-output logic; line values change only on a tick so
  // every bit spans exactly one tick interval.
  always_comb begin
    state_d = state;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    tx_d    = tx;
    ready_d = ready;
    busy_d  = busy;

    case (state)
      IDLE: begin
        // A tick coincident with acceptance is deliberately not consumed.
        if (valid && ready) begin
          shift_d = data;
          par_d   = (Parity == EVEN) ? ^data : ~^data;
          cnt_d   = '0;
          state_d = SYNC;
          ready_d = 1'b0;
          busy_d  = 1'b1;
        end
      end

      SYNC: begin
        // Align the start bit to the bit grid.
        if (tick_c) begin
          state_d = START;
          tx_d    = 1'b0;
        end
      end

      START: begin
        if (tick_c) begin
          state_d = DATA;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          cnt_d   = '0;
        end
      end

      DATA: begin
        // d0 went out on the START tick; each DATA tick emits the next bit
        // until the last data bit has had its full period.
        if (tick_c) begin
          if (cnt_q == LastData) begin
            cnt_d = '0;
            if (HasParity) begin
              state_d = PAR;
              tx_d    = par_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            cnt_d   = cnt_q + CntOne;
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
      end

      PAR: begin
        if (tick_c) begin
          state_d = STOP;
          tx_d    = 1'b1;
          cnt_d   = '0;
        end
      end

      STOP: begin
        if (tick_c) begin
          if (cnt_q == LastStop) begin
            state_d = IDLE;
            ready_d = 1'b1;
            busy_d  = 1'b0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
      end

      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: four configurations (plain, even parity,
// odd parity, two stop bits) share clock, reset and the bit-rate reference.
// A frame-level model predicts tx/ready/busy every cycle; hand-computed
// captures pin the model on the directed vectors.
module tb_uart_tx;
  import uart_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ckin  = 1'b0;
  logic       valid [4];
  logic [7:0] data  [4];
  logic       ready [4];
  logic       tx    [4];
  logic       busy  [4];

  int vectors     = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  uart_tx #(.DataBits(8), .Parity(NONE), .StopBits(1)) u_plain (
    .clock(clock), .reset(reset), .ckin(ckin), .data(data[0]), .valid(valid[0]),
    .ready(ready[0]), .tx(tx[0]), .busy(busy[0]));
  uart_tx #(.DataBits(8), .Parity(EVEN), .StopBits(1)) u_even (
    .clock(clock), .reset(reset), .ckin(ckin), .data(data[1]), .valid(valid[1]),
    .ready(ready[1]), .tx(tx[1]), .busy(busy[1]));
  uart_tx #(.DataBits(8), .Parity(ODD), .StopBits(1)) u_odd (
    .clock(clock), .reset(reset), .ckin(ckin), .data(data[2]), .valid(valid[2]),
    .ready(ready[2]), .tx(tx[2]), .busy(busy[2]));
  uart_tx #(.DataBits(8), .Parity(NONE), .StopBits(2)) u_stop2 (
    .clock(clock), .reset(reset), .ckin(ckin), .data(data[3]), .valid(valid[3]),
    .ready(ready[3]), .tx(tx[3]), .busy(busy[3]));

  // ---------------- bit-rate reference ----------------
  // mode 0: square wave, period 8; mode 1: 1-cycle pulse every 5 clocks.
  // stall_req stretches the next pulse high for 5 extra clocks.
  int ck_mode    = 0;
  int ck_cnt     = 0;
  int stall_left = 0;
  bit stall_req  = 1'b0;

  initial begin
    forever begin
      @(negedge clock);
      #1;
      if (stall_left > 0) begin
        ckin = 1'b1;
        stall_left--;
      end else if (ck_mode == 0) begin
        ckin   = (ck_cnt < 4);
        ck_cnt = (ck_cnt + 1) % 8;
      end else begin
        ckin = (ck_cnt == 0);
        if (ck_cnt == 0 && stall_req) begin
          stall_left = 5;
          stall_req  = 1'b0;
        end
        ck_cnt = (ck_cnt + 1) % 5;
      end
    end
  end

  // ---------------- frame-level model ----------------
  int         par_cfg  [4] = '{0, 2, 1, 0};
  int         stop_cfg [4] = '{1, 1, 1, 2};
  logic       m_tx     [4];
  logic       m_ready  [4];
  logic       m_busy   [4];
  logic [11:0] m_frame [4];
  int         m_len    [4];
  int         m_pos    [4];
  logic       m_prev;

  // Line levels of a whole frame, index 0 = start bit.
  function automatic void build(input logic [7:0] d, input int par, input int stops,
                                output logic [11:0] f, output int len);
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = d;
    len    = 9;
    if (par != 0) begin
      f[9] = (par == 2) ? ^d : ~^d;
      len++;
    end
    len += stops;
  endfunction

  // After acceptance each tick puts the next frame level on the line; the
  // tick after the last level has run its period frees the transmitter.
  always @(posedge clock or posedge reset) begin : model
    logic        tk;
    logic [11:0] f;
    int          len;
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        m_tx[i]    <= 1'b1;
        m_ready[i] <= 1'b1;
        m_busy[i]  <= 1'b0;
        m_pos[i]   <= 0;
        m_len[i]   <= 0;
        m_frame[i] <= '1;
      end
      m_prev <= 1'b0;
    end else begin
      tk = ckin & ~m_prev;
      m_prev <= ckin;
      for (int i = 0; i < 4; i++) begin
        if (m_ready[i] && valid[i]) begin
          build(data[i], par_cfg[i], stop_cfg[i], f, len);
          m_frame[i] <= f;
          m_len[i]   <= len;
          m_pos[i]   <= 0;
          m_ready[i] <= 1'b0;
          m_busy[i]  <= 1'b1;
        end else if (m_busy[i] && tk) begin
          if (m_pos[i] < m_len[i]) begin
            m_tx[i]  <= m_frame[i][m_pos[i]];
            m_pos[i] <= m_pos[i] + 1;
          end else begin
            m_ready[i] <= 1'b1;
            m_busy[i]  <= 1'b0;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clock);
      if (!reset) begin
        for (int i = 0; i < 4; i++) begin
          chk($sformatf("model tx[%0d]", i),    32'(tx[i]),    32'(m_tx[i]));
          chk($sformatf("model ready[%0d]", i), 32'(ready[i]), 32'(m_ready[i]));
          chk($sformatf("model busy[%0d]", i),  32'(busy[i]),  32'(m_busy[i]));
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  logic cap  [0:255];
  logic capr [0:255];

  task automatic wait_level(input int k, input bit is_tx, input logic lvl, input string what);
    int w = 0;
    while (((is_tx ? tx[k] : ready[k]) !== lvl) && w < 400) begin
      @(negedge clock);
      w++;
    end
    if (w >= 400) begin
      vectors++;
      miscompares++;
      $display("FAIL %s timeout: level %b not seen within %0d cycles", what, lvl, w);
    end
  endtask

  task automatic send(input int k, input logic [7:0] d);
    @(negedge clock);
    data[k]  = d;
    valid[k] = 1'b1;
    @(negedge clock);
    wait_level(k, 1'b0, 1'b0, "accept");
    valid[k] = 1'b0;
  endtask

  // Log tx/ready each negedge from the first negedge that shows the start bit.
  task automatic capture(input int k, input int n, input bit stall);
    @(negedge clock);
    wait_level(k, 1'b1, 1'b0, "start bit");
    if (stall) stall_req = 1'b1;
    for (int i = 0; i < n; i++) begin
      cap[i]  = tx[k];
      capr[i] = ready[k];
      @(negedge clock);
    end
  endtask

  function automatic logic [15:0] bits_at(input int base, input int per, input int nb);
    logic [15:0] v;
    v = '0;
    for (int b = 0; b < nb; b++) v[b] = cap[base + b * per + per / 2];
    return v;
  endfunction

  function automatic int first_ready(input int n);
    for (int i = 0; i < n; i++) if (capr[i] === 1'b1) return i;
    return -1;
  endfunction

  task automatic hs_back_to_back();
    @(negedge clock);
    data[3]  = 8'hA3;
    valid[3] = 1'b1;
    @(negedge clock);
    wait_level(3, 1'b0, 1'b0, "b2b accept 1");
    data[3] = 8'h3C;
    wait_level(3, 1'b0, 1'b1, "b2b ready return");
    wait_level(3, 1'b0, 1'b0, "b2b accept 2");
    valid[3] = 1'b0;
  endtask

  int stall_idx [11] = '{2, 7, 12, 17, 22, 27, 32, 37, 42, 47, 52};
  int stall_exp [11] = '{0, 1, 1,  0,  1,  0,  0,  0,  1,  1,  1};

  // ---------------- directed sequence ----------------
  initial begin
    int idx;
    for (int i = 0; i < 4; i++) begin
      valid[i] = 1'b0;
      data[i]  = 8'h00;
    end
    repeat (4) @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("reset tx[%0d]", i),    32'(tx[i]),    32'd1);
      chk($sformatf("reset ready[%0d]", i), 32'(ready[i]), 32'd1);
      chk($sformatf("reset busy[%0d]", i),  32'(busy[i]),  32'd0);
    end
    reset = 1'b0;
    repeat (3) @(negedge clock);

    // Basic 0x55 frame, 8-clock bits.
    fork
      send(0, 8'h55);
      capture(0, 100, 1'b0);
    join
    chk("frame 0x55", 32'(bits_at(0, 8, 10)), 32'h2AA);
    idx = 0;
    while (idx < 100 && cap[idx] === 1'b0) idx++;
    chk("start bit length", 32'(idx), 32'd8);
    chk("ready return 0x55", 32'(first_ready(100)), 32'd80);

    // Parity variants with 0x07.
    fork
      send(1, 8'h07);
      capture(1, 110, 1'b0);
    join
    chk("even parity 0x07", 32'(bits_at(0, 8, 11)), 32'h60E);
    fork
      send(2, 8'h07);
      capture(2, 110, 1'b0);
    join
    chk("odd parity 0x07", 32'(bits_at(0, 8, 11)), 32'h40E);

    // Two stop bits, back-to-back with valid held.
    fork
      hs_back_to_back();
      capture(3, 200, 1'b0);
    join
    chk("b2b frame 0xA3", 32'(bits_at(0, 8, 11)), 32'h746);
    chk("b2b ready return", 32'(first_ready(200)), 32'd88);
    idx = 88;
    while (idx < 200 && cap[idx] !== 1'b0) idx++;
    chk("b2b second start", 32'(idx), 32'd96);
    chk("b2b frame 0x3C", 32'(bits_at(96, 8, 11)), 32'h678);
    repeat (60) @(negedge clock);
    chk("b2b no third frame busy", 32'(busy[3]), 32'd0);

    // Handshake: data change after acceptance and valid while busy.
    fork
      begin
        send(0, 8'h81);
        data[0] = 8'h00;
        repeat (20) @(negedge clock);
        data[0]  = 8'hFF;
        valid[0] = 1'b1;
        @(negedge clock);
        valid[0] = 1'b0;
      end
      capture(0, 100, 1'b0);
    join
    chk("accepted word 0x81", 32'(bits_at(0, 8, 10)), 32'h302);
    repeat (20) @(negedge clock);
    chk("ignored 0xFF busy", 32'(busy[0]), 32'd0);

    // Reset during data bit 3 of 0xF0.
    send(0, 8'hF0);
    wait_level(0, 1'b1, 1'b0, "reset-test start");
    repeat (36) @(negedge clock);
    chk("tx in data bit 3", 32'(tx[0]), 32'd0);
    #2 reset = 1'b1;
    #1;
    chk("async reset tx", 32'(tx[0]), 32'd1);
    chk("async reset busy", 32'(busy[0]), 32'd0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("post-reset ready", 32'(ready[0]), 32'd1);
    chk("post-reset busy", 32'(busy[0]), 32'd0);
    fork
      send(0, 8'h0F);
      capture(0, 100, 1'b0);
    join
    chk("frame 0x0F after reset", 32'(bits_at(0, 8, 10)), 32'h21E);

    // Pulse-type reference, 5-clock bits.
    @(negedge clock);
    ck_mode = 1;
    ck_cnt  = 0;
    repeat (10) @(negedge clock);
    fork
      send(0, 8'h33);
      capture(0, 70, 1'b0);
    join
    chk("pulse frame 0x33", 32'(bits_at(0, 5, 10)), 32'h266);
    chk("pulse ready return", 32'(first_ready(70)), 32'd50);

    // Reference held high for 5 clocks while d0 is on the line.
    fork
      send(0, 8'hC5);
      capture(0, 80, 1'b1);
    join
    for (int i = 0; i < 11; i++)
      chk($sformatf("stall sample %0d", stall_idx[i]), 32'(cap[stall_idx[i]]), 32'(stall_exp[i]));
    chk("stall ready return", 32'(first_ready(80)), 32'd55);

    repeat (20) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    miscompares++;
    $display("FAIL watchdog: simulation did not complete by %0t", $time);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
